// File: rtl/reg_bank_sb.sv
// Clocked register bank with two combinational read ports, one write port,
// a post-reset clearing sequencer and a per-register pending (RAW) scoreboard.
module reg_bank_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] AR1,
    input  logic [ADDR_W-1:0] AR2,
    input  logic [ADDR_W-1:0] AW,
    input  logic              REG_WRITE,
    input  logic [DATA_W-1:0] DIN,
    input  logic              SET_PEND,
    input  logic [ADDR_W-1:0] AP,
    output logic [DATA_W-1:0] DR1,
    output logic [DATA_W-1:0] DR2,
    output logic              BUSY1,
    output logic              BUSY2,
    output logic              READY
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e              state_q;
    logic [ADDR_W:0]     cnt_q;
    logic                ready_q;
    logic [DEPTH-1:0]    pend_q, pend_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                run;
    logic                we_eff;
    logic                set_eff;
    logic [ADDR_W-1:0]   ar [2];
    logic [DATA_W-1:0]   dr [2];
    logic                busy [2];

    assign run     = (state_q == RUN);
    assign we_eff  = run && REG_WRITE && !(ZERO_REG != 0 && AW == '0);
    assign set_eff = run && SET_PEND  && !(ZERO_REG != 0 && AP == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == INIT) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // NOTE: the array has no reset; the INIT sequencer clears it one entry per cycle instead.
    always_ff @(posedge CLK) begin
        if (state_q == INIT) begin
            mem_q[cnt_q[ADDR_W-1:0]] <= '0;
        end else if (we_eff) begin
            mem_q[AW] <= DIN;
        end
    end

    // Release first, then reserve, so a same-cycle reservation marks the new producer.
    // NOTE: combinational blocks start from a full default so no latch can be inferred.
    always_comb begin
        pend_d = pend_q;
        if (we_eff) begin
            pend_d[AW] = 1'b0;
        end
        if (set_eff) begin
            pend_d[AP] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign ar[0] = AR1;
    assign ar[1] = AR2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            dr[p]   = mem_q[ar[p]];
            busy[p] = pend_q[ar[p]];
            if (BYPASS != 0 && we_eff && AW == ar[p]) begin
                dr[p] = DIN;
                if (!(set_eff && AP == ar[p])) begin
                    busy[p] = 1'b0;
                end
            end
            if (!run || (ZERO_REG != 0 && ar[p] == '0)) begin
                dr[p]   = '0;
                busy[p] = 1'b0;
            end
        end
    end

    assign DR1   = dr[0];
    assign DR2   = dr[1];
    assign BUSY1 = busy[0];
    assign BUSY2 = busy[1];
    assign READY = ready_q;

endmodule
